// File: rtl/interp_step_ctrl_if.sv
// Host-side request/status bundle between the config register bank and interp_step_ctrl.
// The host drives the request fields; the controller returns busy/done.
interface interp_step_ctrl_if #(
    parameter int CTRBITS = 32,
    parameter int RAMPW   = 16
);
    logic               i_stb;
    logic [CTRBITS-1:0] i_target;
    logic [RAMPW-1:0]   i_ramp;
    logic               i_abort;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_stb, i_target, i_ramp, i_abort,
        input  o_busy, o_done
    );

    modport slave (
        input  i_stb, i_target, i_ramp, i_abort,
        output o_busy, o_done
    );
endinterface

// File: rtl/interp_step_ctrl.sv
// Step-rate controller for the nearest-neighbour interpolator: slews o_step toward a
// host-requested target by at most i_ramp per input sample, then settles and reports done.
module interp_step_ctrl #(
    parameter int                 CTRBITS   = 32,
    parameter int                 RAMPW     = 16,
    parameter int                 SETTLE    = 8,
    parameter logic [CTRBITS-1:0] INIT_STEP = 32'h8000_0000
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ce,
    interp_step_ctrl_if.slave  host,
    output logic [CTRBITS-1:0] o_step,
    output logic [1:0]         o_state
);

    localparam int CNTW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RAMP   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CTRBITS-1:0] r_step;
    logic [CTRBITS-1:0] w_step_nxt;
    logic [CTRBITS-1:0] r_target;
    logic [CTRBITS-1:0] w_target_nxt;
    logic [RAMPW-1:0]   r_ramp;
    logic [RAMPW-1:0]   w_ramp_nxt;
    logic [CNTW-1:0]    r_cnt;
    logic [CNTW-1:0]    w_cnt_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [CTRBITS-1:0] w_slew;
    logic               w_arrive;

    // One slew step toward target; lands exactly on target when within reach (or ramp==0),
    // otherwise moves by ramp, which cannot cross target and so can never wrap.
    function automatic logic [CTRBITS-1:0] f_slew(
        input logic [CTRBITS-1:0] step,
        input logic [CTRBITS-1:0] target,
        input logic [RAMPW-1:0]   ramp
    );
        logic [CTRBITS:0] d;
        logic [CTRBITS:0] lim;
        lim = (CTRBITS + 1)'(ramp);
        if (target >= step) d = {1'b0, target - step};
        else                d = {1'b0, step - target};
        if (ramp == '0 || d <= lim) f_slew = target;
        else if (target > step)     f_slew = step + CTRBITS'(ramp);
        else                        f_slew = step - CTRBITS'(ramp);
    endfunction

    assign w_slew   = f_slew(r_step, r_target, r_ramp);
    assign w_arrive = (w_slew == r_target);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_step   <= INIT_STEP;
            r_target <= '0;
            r_ramp   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_target <= w_target_nxt;
            r_ramp   <= w_ramp_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_target_nxt = r_target;
        w_ramp_nxt   = r_ramp;
        w_cnt_nxt    = r_cnt;
        // Abort leaves o_step where it is rather than snapping to the target.
        if (host.i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (host.i_stb) begin
                        w_state_nxt  = S_RAMP;
                        w_target_nxt = host.i_target;
                        w_ramp_nxt   = host.i_ramp;
                    end
                end
                S_RAMP: begin
                    if (i_ce) begin
                        w_step_nxt = w_slew;
                        if (w_arrive) begin
                            if (SETTLE == 0) begin
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_state_nxt = S_SETTLE;
                                w_cnt_nxt   = CNTW'(SETTLE);
                            end
                        end
                    end
                end
                S_SETTLE: begin
                    if (i_ce) begin
                        w_cnt_nxt = r_cnt - CNTW'(1);
                        if (r_cnt == CNTW'(1)) w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = 1'b0;
        if (!host.i_abort && i_ce) begin
            if (r_state == S_RAMP && w_arrive && SETTLE == 0) w_done_nxt = 1'b1;
            if (r_state == S_SETTLE && r_cnt == CNTW'(1))     w_done_nxt = 1'b1;
        end
    end

    assign host.o_busy = r_busy;
    assign host.o_done = r_done;
    assign o_step      = r_step;
    assign o_state     = r_state;

endmodule
